// File: rtl/sound_latch_bridge_pkg.sv
// Shared constants for the 68K-to-Z80 sound command bridge.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the Z80 I/O port numbers the address decoder uses for this block,
// the default latch clear value and the default interrupt divider.
package sound_latch_bridge_pkg;

    // Value written into the latch when the Z80 clears it.
    localparam logic [7:0]  SND_LATCH_CLR_DEFAULT = 8'h00;

    // Z80 I/O ports decoded upstream into z80_latch_clr_cs / z80_latch_r_cs.
    localparam logic [7:0]  LATCH_CLR_PORT = 8'h04;
    localparam logic [7:0]  LATCH_R_PORT   = 8'h06;

    // Default number of irq_tick strobes between Z80 maskable interrupts.
    localparam logic [15:0] SND_IRQ_DIV_DEFAULT = 16'd4;

endpackage

// File: rtl/sound_latch_bridge_rise.sv
// 1-bit registered rising-edge detector.
// Latency: rise is combinational from level against the previous-cycle sample.
// Backpressure: none; one rise pulse per low-to-high transition of level.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   level  input level to watch
//   rise   high in the cycle level is 1 and was 0 on the previous clock
module rise_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    // The history register tracks the live input even during reset, so a
    // level that is already high when reset drops does not look like a new
    // edge afterwards.
    always_ff @(posedge clk) begin
        level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/sound_latch_bridge.sv
// Responder side of the 68K-to-Z80 sound command path: byte latch plus Z80 IRQ timer.
// Latency: latch_dout/latch_pending/z80_int_n update 1 clk after the causing edge; latch_oe is combinational.
// Backpressure: none; every 68K write, Z80 clear and ack edge is acted on in the cycle it is seen.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   m68k_din/rw/lds_n   68K write data (low byte latched), R/W, lower data strobe
//   sound_latch_cs      decoded 68K sound latch select (already AS-qualified)
//   z80_rd_n/wr_n       Z80 read / write strobes
//   z80_latch_r_cs      decoded Z80 I/O read of the latch
//   z80_latch_clr_cs    decoded Z80 I/O latch clear
//   M1_n, IORQ_n        Z80 cycle qualifiers (both low = interrupt acknowledge)
//   irq_tick            single-cycle timebase strobe for the IRQ divider
//   latch_dout          registered latch contents to the Z80 data-in mux
//   latch_oe            mux select, high during a Z80 read of the latch port
//   latch_pending       set by a 68K write, cleared by a Z80 clear
//   z80_int_n           Z80 INT_n, held low until acknowledged
module sound_latch_bridge
    import sound_latch_bridge_pkg::*;
#(
    parameter logic [15:0] IRQ_DIV   = SND_IRQ_DIV_DEFAULT,
    parameter logic [7:0]  CLR_VALUE = SND_LATCH_CLR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] m68k_din,
    input  logic        m68k_rw,
    input  logic        m68k_lds_n,
    input  logic        sound_latch_cs,
    input  logic        z80_rd_n,
    input  logic        z80_wr_n,
    input  logic        z80_latch_r_cs,
    input  logic        z80_latch_clr_cs,
    input  logic        M1_n,
    input  logic        IORQ_n,
    input  logic        irq_tick,
    output logic [7:0]  latch_dout,
    output logic        latch_oe,
    output logic        latch_pending,
    output logic        z80_int_n
);

    // ------------------------------------------------------------------
    // Strobe decode and edge detection
    // ------------------------------------------------------------------
    logic wr68;
    logic clr;
    logic ack;
    logic wr68_rise;
    logic clr_rise;
    logic ack_rise;

    assign wr68 = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    assign clr  = z80_latch_clr_cs & ~z80_wr_n;
    assign ack  = ~M1_n & ~IORQ_n;

    // Edge-triggering makes a long 68K bus cycle (wait states) or a
    // multi-clock Z80 I/O cycle act exactly once.
    rise_edge_det u_wr68_edge (
        .clk   (clk),
        .reset (reset),
        .level (wr68),
        .rise  (wr68_rise)
    );

    rise_edge_det u_clr_edge (
        .clk   (clk),
        .reset (reset),
        .level (clr),
        .rise  (clr_rise)
    );

    rise_edge_det u_ack_edge (
        .clk   (clk),
        .reset (reset),
        .level (ack),
        .rise  (ack_rise)
    );

    // Only the low byte reaches the Z80; the upper byte is intentionally dropped.
    logic unused_din_hi;
    assign unused_din_hi = ^m68k_din[15:8];

    // ------------------------------------------------------------------
    // Sound command latch
    // ------------------------------------------------------------------
    logic [7:0] latch_q;
    logic       pending_q;

    // A 68K write landing in the same cycle as a Z80 clear wins: losing a
    // fresh command is worse than the Z80 seeing it a second time.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q   <= 8'h00;
            pending_q <= 1'b0;
        end else if (wr68_rise) begin
            latch_q   <= m68k_din[7:0];
            pending_q <= 1'b1;
        end else if (clr_rise) begin
            latch_q   <= CLR_VALUE;
            pending_q <= 1'b0;
        end
    end

    // Reads are side-effect free; a read in the capture cycle sees the
    // old registered value because latch_dout is taken from the register.
    assign latch_dout    = latch_q;
    assign latch_pending = pending_q;
    assign latch_oe      = z80_latch_r_cs & ~z80_rd_n;

    // ------------------------------------------------------------------
    // Periodic Z80 interrupt
    // ------------------------------------------------------------------
    logic [15:0] div_q;
    logic        int_n_q;
    logic        expire;

    assign expire = irq_tick & (div_q == (IRQ_DIV - 16'd1));

    // The divider free-runs regardless of INT_n; expiries while INT_n is
    // already low are simply absorbed (no interrupt queueing). An expiry
    // coinciding with an acknowledge re-asserts the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= 16'd0;
            int_n_q <= 1'b1;
        end else begin
            if (irq_tick) begin
                if (expire) begin
                    div_q <= 16'd0;
                end else begin
                    div_q <= div_q + 16'd1;
                end
            end

            if (expire) begin
                int_n_q <= 1'b0;
            end else if (ack_rise) begin
                int_n_q <= 1'b1;
            end
        end
    end

    assign z80_int_n = int_n_q;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Self-checking bench for sound_latch_bridge: directed scenarios plus a
// randomized transaction sequence compared against a transaction-level model.
// Latency: n/a. Backpressure: n/a.
module tb_sound_latch_bridge;

    localparam logic [15:0] P_IRQ_DIV = 16'd4;
    localparam logic [7:0]  P_CLR     = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] m68k_din = 16'h0000;
    logic        m68k_rw = 1'b1;
    logic        m68k_lds_n = 1'b1;
    logic        sound_latch_cs = 1'b0;
    logic        z80_rd_n = 1'b1;
    logic        z80_wr_n = 1'b1;
    logic        z80_latch_r_cs = 1'b0;
    logic        z80_latch_clr_cs = 1'b0;
    logic        M1_n = 1'b1;
    logic        IORQ_n = 1'b1;
    logic        irq_tick = 1'b0;
    logic [7:0]  latch_dout;
    logic        latch_oe;
    logic        latch_pending;
    logic        z80_int_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sound_latch_bridge #(
        .IRQ_DIV   (P_IRQ_DIV),
        .CLR_VALUE (P_CLR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m68k_din         (m68k_din),
        .m68k_rw          (m68k_rw),
        .m68k_lds_n       (m68k_lds_n),
        .sound_latch_cs   (sound_latch_cs),
        .z80_rd_n         (z80_rd_n),
        .z80_wr_n         (z80_wr_n),
        .z80_latch_r_cs   (z80_latch_r_cs),
        .z80_latch_clr_cs (z80_latch_clr_cs),
        .M1_n             (M1_n),
        .IORQ_n           (IORQ_n),
        .irq_tick         (irq_tick),
        .latch_dout       (latch_dout),
        .latch_oe         (latch_oe),
        .latch_pending    (latch_pending),
        .z80_int_n        (z80_int_n)
    );

    // Advance one clock; inputs driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_on(input logic [15:0] d);
        m68k_din = d; sound_latch_cs = 1'b1; m68k_rw = 1'b0; m68k_lds_n = 1'b0;
    endtask

    task automatic wr_off();
        sound_latch_cs = 1'b0; m68k_rw = 1'b1; m68k_lds_n = 1'b1;
    endtask

    task automatic clr_on();
        z80_latch_clr_cs = 1'b1; z80_wr_n = 1'b0;
    endtask

    task automatic clr_off();
        z80_latch_clr_cs = 1'b0; z80_wr_n = 1'b1;
    endtask

    task automatic ack_on();
        M1_n = 1'b0; IORQ_n = 1'b0;
    endtask

    task automatic ack_off();
        M1_n = 1'b1; IORQ_n = 1'b1;
    endtask

    // One irq_tick strobe, leaving the bus idle afterwards.
    task automatic tick();
        irq_tick = 1'b1;
        step();
        irq_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (latch_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", latch_dout); end
        checks++; if (latch_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", latch_pending); end
        checks++; if (z80_int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n got %b exp 1", z80_int_n); end
        checks++; if (latch_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", latch_oe); end
    endtask

    task automatic test_write_capture();
        wr_on(16'h12A5);
        step();
        checks++; if (latch_dout !== 8'hA5) begin errors++; $display("FAIL wr_dout got %h exp a5", latch_dout); end
        checks++; if (latch_pending !== 1'b1) begin errors++; $display("FAIL wr_pending got %b exp 1", latch_pending); end
        // Data changes mid-cycle must not be re-captured while strobe stays high.
        m68k_din = 16'h00FF;
        step(); step(); step();
        checks++; if (latch_dout !== 8'hA5) begin errors++; $display("FAIL wr_once got %h exp a5", latch_dout); end
        wr_off();
        step();
    endtask

    task automatic test_read_clear();
        z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0;
        #1;
        checks++; if (latch_oe !== 1'b1) begin errors++; $display("FAIL rd_oe got %b exp 1", latch_oe); end
        step();
        checks++; if (latch_dout !== 8'hA5) begin errors++; $display("FAIL rd_dout got %h exp a5", latch_dout); end
        checks++; if (latch_pending !== 1'b1) begin errors++; $display("FAIL rd_pending got %b exp 1", latch_pending); end
        z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1;
        #1;
        checks++; if (latch_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_off got %b exp 0", latch_oe); end
        clr_on();
        step();
        checks++; if (latch_dout !== P_CLR) begin errors++; $display("FAIL clr_dout got %h exp %h", latch_dout, P_CLR); end
        checks++; if (latch_pending !== 1'b0) begin errors++; $display("FAIL clr_pending got %b exp 0", latch_pending); end
        clr_off();
        step();
    endtask

    task automatic test_simultaneous();
        // Read overlapping the capture cycle still shows the old value.
        z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0;
        wr_on(16'hFF3C);
        clr_on();
        #1;
        checks++; if (latch_dout !== P_CLR) begin errors++; $display("FAIL rd_during_wr got %h exp %h", latch_dout, P_CLR); end
        step();
        checks++; if (latch_dout !== 8'h3C) begin errors++; $display("FAIL simul_dout got %h exp 3c", latch_dout); end
        checks++; if (latch_pending !== 1'b1) begin errors++; $display("FAIL simul_pending got %b exp 1", latch_pending); end
        wr_off(); clr_off();
        z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1;
        step();
    endtask

    task automatic test_irq_basic();
        for (int t = 1; t <= 8; t++) begin
            repeat (9) step();
            tick();
            checks++;
            if (z80_int_n !== ((t % 4) != 0)) begin
                errors++; $display("FAIL irq_tick%0d got %b exp %b", t, z80_int_n, ((t % 4) != 0));
            end
            if (t == 4) begin
                ack_on(); step();
                checks++; if (z80_int_n !== 1'b1) begin errors++; $display("FAIL irq_ack got %b exp 1", z80_int_n); end
                ack_off(); step();
            end
        end
        ack_on(); step(); ack_off(); step();
    endtask

    task automatic test_irq_withhold();
        for (int t = 1; t <= 16; t++) begin
            repeat (3) step();
            tick();
            checks++;
            if (z80_int_n !== (t < 4 || (t > 12 && t < 16))) begin
                errors++; $display("FAIL hold_tick%0d got %b exp %b", t, z80_int_n, (t < 4 || (t > 12 && t < 16)));
            end
            if (t == 12) begin
                ack_on(); step();
                checks++; if (z80_int_n !== 1'b1) begin errors++; $display("FAIL hold_ack got %b exp 1", z80_int_n); end
                ack_off(); step();
            end
        end
    endtask

    task automatic test_ack_expiry();
        // INT_n is low from the previous expiry; 3 more ticks to the next one.
        repeat (3) begin step(); tick(); end
        ack_on(); irq_tick = 1'b1;
        step();
        irq_tick = 1'b0;
        checks++; if (z80_int_n !== 1'b0) begin errors++; $display("FAIL ack_vs_expiry got %b exp 0", z80_int_n); end
        ack_off(); step();
        ack_on(); step();
        checks++; if (z80_int_n !== 1'b1) begin errors++; $display("FAIL ack_after got %b exp 1", z80_int_n); end
        ack_off(); step();
    endtask

    task automatic test_reset_mid();
        repeat (4) begin step(); tick(); end
        checks++; if (z80_int_n !== 1'b0) begin errors++; $display("FAIL mid_pre_int got %b exp 0", z80_int_n); end
        wr_on(16'h0055);
        step();
        reset = 1'b1;
        step();
        checks++; if (z80_int_n !== 1'b1) begin errors++; $display("FAIL mid_int got %b exp 1", z80_int_n); end
        checks++; if (latch_dout !== 8'h00) begin errors++; $display("FAIL mid_dout got %h exp 00", latch_dout); end
        reset = 1'b0;
        m68k_din = 16'h0077;
        step(); step();
        checks++; if (latch_dout !== 8'h00) begin errors++; $display("FAIL mid_nocap got %h exp 00", latch_dout); end
        checks++; if (latch_pending !== 1'b0) begin errors++; $display("FAIL mid_pending got %b exp 0", latch_pending); end
        wr_off(); step();
        // Divider restarted from zero: fourth tick after reset fires.
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks++;
            if (z80_int_n !== (t != 4)) begin errors++; $display("FAIL mid_div%0d got %b exp %b", t, z80_int_n, (t != 4)); end
        end
    endtask

    // Transaction-level model: a write sets data+pending, a clear loads the
    // clear value, every IRQ_DIV-th tick since reset raises the interrupt,
    // and an acknowledge drops it.
    task automatic test_random();
        logic [7:0] m_latch;
        logic       m_pend;
        logic       m_int_n;
        int         m_ticks;
        logic [15:0] d;
        int         op;
        int         len;
        do_reset();
        m_latch = 8'h00; m_pend = 1'b0; m_int_n = 1'b1; m_ticks = 0;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 4);
            len = $urandom_range(1, 4);
            case (op)
                0: begin
                    d = 16'($urandom);
                    wr_on(d);
                    repeat (len) step();
                    wr_off(); step();
                    m_latch = d[7:0]; m_pend = 1'b1;
                end
                1: begin
                    clr_on();
                    repeat (len) step();
                    clr_off(); step();
                    m_latch = P_CLR; m_pend = 1'b0;
                end
                2: begin
                    z80_latch_r_cs = 1'b1; z80_rd_n = 1'b0;
                    repeat (len) step();
                    checks++; if (latch_oe !== 1'b1) begin errors++; $display("FAIL rnd_oe[%0d] got %b exp 1", i, latch_oe); end
                    z80_latch_r_cs = 1'b0; z80_rd_n = 1'b1;
                    step();
                end
                3: begin
                    tick();
                    m_ticks++;
                    if (m_ticks % int'(P_IRQ_DIV) == 0) m_int_n = 1'b0;
                end
                default: begin
                    ack_on();
                    repeat (len) step();
                    ack_off(); step();
                    m_int_n = 1'b1;
                end
            endcase
            checks++; if (latch_dout !== m_latch) begin errors++; $display("FAIL rnd_dout[%0d] got %h exp %h", i, latch_dout, m_latch); end
            checks++; if (latch_pending !== m_pend) begin errors++; $display("FAIL rnd_pending[%0d] got %b exp %b", i, latch_pending, m_pend); end
            checks++; if (z80_int_n !== m_int_n) begin errors++; $display("FAIL rnd_int_n[%0d] got %b exp %b", i, z80_int_n, m_int_n); end
        end
    endtask

    initial begin
        test_reset();
        test_write_capture();
        test_read_clear();
        test_simultaneous();
        test_irq_basic();
        test_irq_withhold();
        test_ack_expiry();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_latch_bridge.md
Name: sound_latch_bridge

Overview:
- Responder side of the 68K→Z80 sound command path.
- Captures the 68K byte write decoded as the sound latch select, holds it for the Z80 to read over I/O, and clears it on the Z80 latch-clear port.
- Generates the periodic Z80 maskable interrupt and releases it on the Z80 interrupt-acknowledge cycle.
- Sits between the address decoder selects and the Z80 data-in mux.

Parameters:
- IRQ_DIV, 16'd4, number of irq_tick pulses between Z80 interrupts; legal range 1..65535.
- CLR_VALUE, 8'h00, value loaded into the latch by a Z80 clear.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m68k_din  in  16  68K write data; latch takes bits [7:0]
- m68k_rw  in  1  68K R/W (1 = read)
- m68k_lds_n  in  1  68K lower data strobe, active low
- sound_latch_cs  in  1  decoded 68K sound latch select; already qualified by address strobe
- z80_rd_n  in  1  Z80 RD_n
- z80_wr_n  in  1  Z80 WR_n
- z80_latch_r_cs  in  1  decoded Z80 I/O read of latch (port 06h)
- z80_latch_clr_cs  in  1  decoded Z80 I/O latch clear (port 04h)
- M1_n  in  1  Z80 M1_n
- IORQ_n  in  1  Z80 IORQ_n
- irq_tick  in  1  single-cycle timebase strobe for the IRQ divider
- latch_dout  out  8  latch contents to the Z80 data-in mux
- latch_oe  out  1  high while z80_latch_r_cs & !z80_rd_n (mux select)
- latch_pending  out  1  set by a 68K write, cleared by a Z80 clear
- z80_int_n  out  1  Z80 INT_n, active low

Behaviour:
- Reset values: latch_dout = 8'h00, latch_pending = 0, z80_int_n = 1, divider = 0, edge registers = inactive.
- 68K write strobe: wr68 = sound_latch_cs & !m68k_rw & !m68k_lds_n.
  - Register wr68 each clk.
  - Act only on its rising edge, so each bus cycle causes exactly one capture regardless of its length.
  - On the edge: latch <= m68k_din[7:0], pending <= 1; visible on latch_dout the next cycle (1-cycle latency).
- Z80 clear: clr = z80_latch_clr_cs & !z80_wr_n, rising-edge detected.
  - On the edge: latch <= CLR_VALUE, pending <= 0.
- Simultaneous 68K write edge and Z80 clear edge in one cycle: the 68K write wins (new data, pending = 1).
- Z80 read:
  - latch_oe is combinational from inputs.
  - latch_dout is the registered latch.
  - A read never modifies latch or pending.
  - A read during the same cycle as a 68K capture returns the old value.
- IRQ divider: 16-bit counter, advances only on irq_tick.
  - When it equals IRQ_DIV-1 and irq_tick is high: counter <= 0 and z80_int_n <= 0.
  - Otherwise it increments.
  - IRQ_DIV = 1 means every tick fires.
- IRQ acknowledge: ack = !M1_n & !IORQ_n, rising-edge detected; on the edge z80_int_n <= 1.
- Ack edge coinciding with a divider expiry: the new interrupt wins (z80_int_n stays 0).
- Expiry while z80_int_n is already 0: no change; missed interrupts are not counted.
- z80_int_n is level-held until acknowledged; there is no timeout.
- The divider keeps running while an interrupt is pending.
- Reset asserted mid-operation (during a 68K write cycle or an active IRQ): all state returns to reset values next clk.
  - A still-active wr68 or ack level present when reset deasserts is not treated as a new edge; edge registers reload from the current inputs during reset.
- Only the stated inputs are sampled; the block does not check address or pcb type (the decoder owns that).

Decomposition:
- Shared package: SND_LATCH_CLR_DEFAULT (8'h00), Z80 port constants (LATCH_CLR_PORT 8'h04, LATCH_R_PORT 8'h06), default IRQ_DIV.
- One natural sub-module, rise_edge_det (1-bit registered rising-edge detector), instantiated three times: 68K write, Z80 clear, IRQ ack.
- Divider and latch stay inline.

Test Plan:
- Reset, then 68K write of 16'h12A5 with sound_latch_cs held 4 cycles -> latch_dout = 8'hA5 after 1 cycle, pending = 1, exactly one capture.
- Z80 read (z80_latch_r_cs, rd_n = 0) -> latch_oe = 1, latch_dout = 8'hA5, pending unchanged; then Z80 clear -> latch_dout = 8'h00, pending = 0.
- 68K write 8'h3C and Z80 clear edge in the same cycle -> latch_dout = 8'h3C, pending = 1.
- IRQ_DIV = 4, irq_tick every 10 clk -> z80_int_n falls on the 4th tick; M1_n = IORQ_n = 0 edge -> z80_int_n = 1; next fall on the 8th tick.
- Withhold ack across 3 expiries, then ack -> z80_int_n held low throughout, high after ack, next fall at the following expiry (no queued IRQs).
- Ack edge on the same cycle as an expiry -> z80_int_n stays 0. Assert reset mid-IRQ with wr68 held high -> z80_int_n = 1, latch = 00, no capture after reset release.
